// File: rtl/rename_pkg.sv
// Shared rename-stage types: map image and checkpoint tag.
package rename_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PREG_W    = 7;
    localparam int NUM_CKPT  = 4;

    typedef logic [0:ARCH_REGS-1][PREG_W-1:0] map_t;
    typedef logic [$clog2(NUM_CKPT)-1:0]      ckpt_tag_t;

    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < ARCH_REGS; i++) m[i] = PREG_W'(i);
        return m;
    endfunction
endpackage

// File: rtl/ckpt_ctrl_if.sv
// Rename / branch-resolve / map-table bus of the checkpoint controller.
interface ckpt_ctrl_if #(parameter int NUM_CKPT = 4);
    logic                        branch_valid;
    rename_pkg::map_t            map_in;
    logic [$clog2(NUM_CKPT)-1:0] ckpt_tag;
    logic                        ckpt_full;
    logic                        resolve_valid;
    logic [$clog2(NUM_CKPT)-1:0] resolve_tag;
    logic                        resolve_mispredict;
    logic                        mispredict;
    rename_pkg::map_t            re_map;

    modport master (
        output branch_valid, map_in, resolve_valid, resolve_tag, resolve_mispredict,
        input  ckpt_tag, ckpt_full, mispredict, re_map
    );
    modport slave (
        input  branch_valid, map_in, resolve_valid, resolve_tag, resolve_mispredict,
        output ckpt_tag, ckpt_full, mispredict, re_map
    );
endinterface

// File: rtl/ckpt_store.sv
// Snapshot array: one write port, one combinational read port, no reset.
module ckpt_store
    import rename_pkg::*;
#(
    parameter int NUM_CKPT = 4
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(NUM_CKPT)-1:0] widx,
    input  map_t                        wdata,
    input  logic [$clog2(NUM_CKPT)-1:0] ridx,
    output map_t                        rdata
);
    map_t mem [NUM_CKPT];

    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
    end

    assign rdata = mem[ridx];
endmodule

// File: rtl/ckpt_ctrl.sv
// Branch checkpoint controller: allocate, in-order retire, mispredict restore.
// Optional CKPT_STATS_EN adds saturating alloc/restore/full-stall counters.
module ckpt_ctrl
    import rename_pkg::*;
#(
    parameter int NUM_CKPT = 4
) (
    input  logic        clk,
    input  logic        reset,
    ckpt_ctrl_if.slave  bus
`ifdef CKPT_STATS_EN
    ,
    output logic [31:0] stat_alloc_cnt,
    output logic [31:0] stat_restore_cnt,
    output logic [31:0] stat_full_stall_cnt
`endif
);
    localparam int TW = $clog2(NUM_CKPT);

    logic [TW:0]         head, tail, count;
    logic [TW-1:0]       head_idx, tail_idx, rtag;
    logic [NUM_CKPT-1:0] valid, done, epoch, squash;
    logic                full, restore, correct, alloc, retire;
    logic                mispredict_q;
    map_t                re_map_q, rd_map;

    assign head_idx = head[TW-1:0];
    assign tail_idx = tail[TW-1:0];
    assign rtag     = bus.resolve_tag;
    assign count    = tail - head;
    assign full     = (count == (TW+1)'(NUM_CKPT));

    assign restore = bus.resolve_valid &&  bus.resolve_mispredict && valid[rtag];
    assign correct = bus.resolve_valid && !bus.resolve_mispredict && valid[rtag];
    assign alloc   = bus.branch_valid && !full && !restore;
    assign retire  = valid[head_idx] && done[head_idx] && !restore;

    // Slots at or beyond the mispredicted tag in age order (relative to head) are younger.
    always_comb begin
        squash = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            logic [TW-1:0] rel_i, rel_t;
            rel_i = TW'(i) - head_idx;
            rel_t = rtag - head_idx;
            squash[i] = (rel_i >= rel_t);
        end
    end

    ckpt_store #(.NUM_CKPT(NUM_CKPT)) u_store (
        .clk   (clk),
        .we    (alloc),
        .widx  (tail_idx),
        .wdata (bus.map_in),
        .ridx  (rtag),
        .rdata (rd_map)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            valid        <= '0;
            done         <= '0;
            epoch        <= '0;
            mispredict_q <= 1'b0;
            re_map_q     <= identity_map();
        end else begin
            mispredict_q <= restore;
            if (restore) begin
                re_map_q <= rd_map;
                valid    <= valid & ~squash;
                done     <= done & ~squash;
                // The slot's epoch bit rebuilds the wrap bit so count is correct after rollback.
                tail     <= {epoch[rtag], rtag};
            end else begin
                if (correct) done[rtag] <= 1'b1;
                if (retire) begin
                    valid[head_idx] <= 1'b0;
                    done[head_idx]  <= 1'b0;
                    head            <= head + 1'b1;
                end
                if (alloc) begin
                    valid[tail_idx] <= 1'b1;
                    done[tail_idx]  <= 1'b0;
                    epoch[tail_idx] <= tail[TW];
                    tail            <= tail + 1'b1;
                end
            end
        end
    end

    assign bus.ckpt_tag   = tail_idx;
    assign bus.ckpt_full  = full;
    assign bus.mispredict = mispredict_q;
    assign bus.re_map     = re_map_q;

`ifdef CKPT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_alloc_cnt      <= '0;
            stat_restore_cnt    <= '0;
            stat_full_stall_cnt <= '0;
        end else begin
            if (alloc && stat_alloc_cnt != '1)
                stat_alloc_cnt <= stat_alloc_cnt + 1'b1;
            if (mispredict_q && stat_restore_cnt != '1)
                stat_restore_cnt <= stat_restore_cnt + 1'b1;
            if (bus.branch_valid && full && stat_full_stall_cnt != '1)
                stat_full_stall_cnt <= stat_full_stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ckpt_ctrl.sv
// Directed bench for ckpt_ctrl with a restore-image scoreboard.
module tb_ckpt_ctrl;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic reset;

    ckpt_ctrl_if #(.NUM_CKPT(4)) bus ();

`ifdef CKPT_STATS_EN
    logic [31:0] s_alloc, s_restore, s_stall;
`endif

    ckpt_ctrl #(.NUM_CKPT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CKPT_STATS_EN
        ,
        .stat_alloc_cnt      (s_alloc),
        .stat_restore_cnt    (s_restore),
        .stat_full_stall_cnt (s_stall)
`endif
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    map_t snap [4];
    map_t exp_q [$];

    function automatic map_t mk_map(input int seed);
        map_t m;
        for (int i = 0; i < ARCH_REGS; i++) m[i] = PREG_W'((seed * 13 + i * 3 + 1) % 128);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_map(input string tag, input map_t obs, input map_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alloc(input map_t m, input int exp_tag);
        bus.branch_valid = 1'b1;
        bus.map_in       = m;
        #1;
        chk("alloc_tag", 32'(bus.ckpt_tag), exp_tag);
        snap[exp_tag] = m;
        tick();
        bus.branch_valid = 1'b0;
    endtask

    task automatic resolve(input int tag, input bit mp);
        bus.resolve_valid      = 1'b1;
        bus.resolve_tag        = 2'(tag);
        bus.resolve_mispredict = mp;
        tick();
        bus.resolve_valid      = 1'b0;
        bus.resolve_mispredict = 1'b0;
    endtask

    task automatic chk_restore(input bit exp);
        chk("mispredict", 32'(bus.mispredict), 32'(exp));
        if (exp && exp_q.size() > 0) chk_map("re_map", bus.re_map, exp_q.pop_front());
    endtask

    initial begin
        map_t m;
        reset                  = 1'b1;
        bus.branch_valid       = 1'b0;
        bus.map_in             = '0;
        bus.resolve_valid      = 1'b0;
        bus.resolve_tag        = '0;
        bus.resolve_mispredict = 1'b0;
        #3;
        chk("rst_full", 32'(bus.ckpt_full), 0);
        chk("rst_tag", 32'(bus.ckpt_tag), 0);
        chk("rst_mispredict", 32'(bus.mispredict), 0);
        chk("rst_remap5", 32'(bus.re_map[5]), 5);
        tick();
        reset = 1'b0;

        // Fill all four slots, then an ignored fifth branch.
        for (int i = 0; i < 4; i++) alloc(mk_map(i), i);
        chk("full_after_4", 32'(bus.ckpt_full), 1);
        bus.branch_valid = 1'b1;
        bus.map_in       = mk_map(99);
        #1;
        chk("full_tag_hold", 32'(bus.ckpt_tag), 0);
        tick();
        bus.branch_valid = 1'b0;
        chk("full_stays", 32'(bus.ckpt_full), 1);
        chk("full_tag_after", 32'(bus.ckpt_tag), 0);

        // Mispredict on head frees everything; slot 0 must not hold the ignored map.
        exp_q.push_back(snap[0]);
        resolve(0, 1'b1);
        chk_restore(1'b1);
        chk("flush_full", 32'(bus.ckpt_full), 0);
        chk("flush_tag", 32'(bus.ckpt_tag), 0);
        tick();
        chk("mp_one_cycle", 32'(bus.mispredict), 0);

        // Out-of-order correct resolves; retire stays in order.
        alloc(mk_map(10), 0);
        alloc(mk_map(11), 1);
        alloc(mk_map(12), 2);
        resolve(2, 1'b0);
        resolve(0, 1'b0);
        tick();
        tick();
        chk("ooo_tag", 32'(bus.ckpt_tag), 3);
        alloc(mk_map(13), 3);
        chk("ooo_not_full", 32'(bus.ckpt_full), 0);
        alloc(mk_map(14), 0);
        chk("ooo_head_at_1", 32'(bus.ckpt_full), 1);
        resolve(1, 1'b0);
        chk("retire_pending", 32'(bus.ckpt_full), 1);
        tick();
        chk("retire_slot1", 32'(bus.ckpt_full), 0);
        chk("retire_tag", 32'(bus.ckpt_tag), 1);
        tick();
        alloc(mk_map(15), 1);
        chk("retire_slot2", 32'(bus.ckpt_full), 0);
        alloc(mk_map(16), 2);
        chk("refull", 32'(bus.ckpt_full), 1);
        exp_q.push_back(snap[3]);
        resolve(3, 1'b1);
        chk_restore(1'b1);
        chk("flush2_full", 32'(bus.ckpt_full), 0);
        chk("flush2_tag", 32'(bus.ckpt_tag), 3);
        tick();

        // Reset during a pending restore pulse.
        alloc(mk_map(17), 3);
        resolve(3, 1'b1);
        chk("mp_before_reset", 32'(bus.mispredict), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_mispredict", 32'(bus.mispredict), 0);
        chk("mid_rst_tag", 32'(bus.ckpt_tag), 0);
        chk("mid_rst_remap5", 32'(bus.re_map[5]), 5);
        tick();
        reset = 1'b0;

        // Snapshot contents restored on mispredict of tag 1.
        alloc(mk_map(20), 0);
        m = mk_map(21); m[3] = 7'd40;
        alloc(m, 1);
        m = mk_map(22); m[3] = 7'd55;
        alloc(m, 2);
        exp_q.push_back(snap[1]);
        resolve(1, 1'b1);
        chk_restore(1'b1);
        chk("remap3_40", 32'(bus.re_map[3]), 40);
        alloc(mk_map(23), 1);
        chk("mp_dropped", 32'(bus.mispredict), 0);

        // Late resolves on squashed tag 2.
        resolve(2, 1'b1);
        chk("late_mp", 32'(bus.mispredict), 0);
        chk("late_mp_tag", 32'(bus.ckpt_tag), 2);
        resolve(2, 1'b0);
        tick();
        chk("late_ok_mp", 32'(bus.mispredict), 0);
        chk("late_ok_tag", 32'(bus.ckpt_tag), 2);

        // Mispredict on head with a same-cycle branch: branch dropped.
        exp_q.push_back(snap[0]);
        bus.branch_valid = 1'b1;
        bus.map_in       = mk_map(30);
        resolve(0, 1'b1);
        bus.branch_valid = 1'b0;
        chk_restore(1'b1);
        chk("same_cyc_tag", 32'(bus.ckpt_tag), 0);
        chk("same_cyc_full", 32'(bus.ckpt_full), 0);
        for (int i = 0; i < 3; i++) alloc(mk_map(40 + i), i);
        chk("cnt0_not_full", 32'(bus.ckpt_full), 0);
        alloc(mk_map(43), 3);
        chk("cnt0_full", 32'(bus.ckpt_full), 1);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ckpt_ctrl.md
# ckpt_ctrl

Branch checkpoint controller for the rename stage. It snapshots the architectural-to-physical map on every renamed branch and hands the branch a checkpoint tag. It retires checkpoints when branches resolve correctly. On a misprediction it drives the restore (`mispredict` pulse plus `re_map` image) into the rename map table and frees the checkpoint and every younger one. It sits between rename, the map table and the branch-resolution unit.

## Interface
Parameters:
- `NUM_CKPT`, 4: checkpoint slots; power of two, ≥2.
- `ARCH_REGS`, 32: architectural registers per snapshot.
- `PREG_W`, 7: physical register index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `branch_valid` in 1: rename is dispatching a branch this cycle.
- `map_in` in `ARCH_REGS`×`PREG_W`: current map table output; captured on allocation.
- `ckpt_tag` out `$clog2(NUM_CKPT)`: tag for the branch; combinational, equals tail index.
- `ckpt_full` out 1: no free slot; rename must stall branches.
- `resolve_valid` in 1: a branch resolved.
- `resolve_tag` in `$clog2(NUM_CKPT)`: tag of the resolved branch.
- `resolve_mispredict` in 1: the resolved branch mispredicted.
- `mispredict` out 1: registered restore pulse to the map table.
- `re_map` out `ARCH_REGS`×`PREG_W`: restore image, valid while `mispredict` is high.

## Operation
- State: `NUM_CKPT` snapshot slots, per-slot `valid` and `done` bits, and `head`/`tail` pointers. Each pointer carries an extra wrap bit. `count = tail - head` (full width).
- Allocate: `branch_valid && !ckpt_full && !restore_this_cycle` → `slot[tail] <= map_in`, `valid=1`, `done=0`, `tail++`.
- `branch_valid` while full: ignored, with no state change.
- Correct resolve: `resolve_valid && !resolve_mispredict && valid[resolve_tag]` → `done[resolve_tag]=1`. Resolution may arrive out of order.
- Retire: when `valid[head] && done[head]` and no restore this cycle, clear `valid[head]` and `head++`. At most one retire per cycle.
- Mispredict resolve on valid tag `t`:
  - Register `re_map <= slot[t]` and `mispredict <= 1`.
  - Clear `valid` and `done` for `t` and all younger slots, walking circularly from `t` to `tail-1`.
  - Set `tail <= t` with its wrap bit taken from the slot's allocation epoch.
  - Suppress allocation and retirement in that cycle.
- Resolve with `valid[resolve_tag]==0`: ignored. This covers branches already squashed by an older mispredict.
- `ckpt_full = (count == NUM_CKPT)`.

## Timing
- Reset values:
  - `head=tail=0`, all `valid`/`done`=0.
  - `ckpt_full=0`, `ckpt_tag=0`, `mispredict=0`.
  - `re_map[i]=i` (identity).
  - Snapshot contents are don't-care.
- Allocation: tag is visible in the same cycle. The snapshot is written at the next edge, and `ckpt_full` updates at that edge.
- Restore latency: resolve in cycle N → `mispredict=1` and `re_map` valid in cycle N+1 only. The map table loads at the end of N+1. `mispredict` is low in N+2 unless another restore occurs.
- Freed slots are allocatable from cycle N+1.
- Same-cycle `branch_valid` and mispredict: the mispredict wins and the branch is not allocated, because rename is flushed.
- Mispredict on `t == head`: every checkpoint is freed, `count=0`, and `head` is unchanged.
- Pointer wrap is modulo `NUM_CKPT`. The wrap bit distinguishes full from empty.
- Reset asserted mid-operation: all state clears immediately and any pending `mispredict` drops.

## Configuration
- `CKPT_STATS_EN` defined: adds outputs `stat_alloc_cnt`, `stat_restore_cnt`, `stat_full_stall_cnt` (32 bits each, saturating, reset 0).
  - `stat_alloc_cnt` increments per allocation.
  - `stat_restore_cnt` increments per `mispredict` pulse.
  - `stat_full_stall_cnt` increments per cycle with `branch_valid && ckpt_full`.
- Undefined: these ports and counters are absent; functional behaviour is identical.

## Structure
- Package `rename_pkg` holds:
  - `ARCH_REGS` and `PREG_W` constants.
  - `map_t` (`[0:ARCH_REGS-1][PREG_W-1:0]`), shared with the map table.
  - `ckpt_tag_t`.
- Sub-module `ckpt_store`: `NUM_CKPT`-entry snapshot array with one write port (index, `map_t`) and one combinational read port. `ckpt_ctrl` holds the pointers, bits and restore logic.

## Test plan
- Reset: `head=tail=0`, `ckpt_full=0`, `mispredict=0`, `re_map[5]=5`.
- Four branches allocated back to back (`NUM_CKPT`=4) → tags 0,1,2,3. `ckpt_full=1` after the 4th edge. A 5th `branch_valid` is ignored and the count stays 4.
- Allocate tags 0..2, then resolve tag 2 correct, then tag 0 correct:
  - Head advances past 0 only; tag 1 is still pending.
  - Resolving tag 1 correct → head retires slot 1 and then slot 2 on consecutive cycles.
- Snapshot at tag 1 with `map_in[3]=40`; later `map_in[3]=55`; mispredict tag 1:
  - Next cycle: `mispredict=1` and `re_map[3]=40` for one cycle.
  - Tags 1 and 2 are freed, and the next allocation receives tag 1.
- A mispredict on tag 0 and `branch_valid` in the same cycle → no allocation, count=0. The following branch gets tag 0.
- A late resolve on squashed tag 2 (mispredict or correct) → no `mispredict` pulse and no state change.
